// File: rtl/vga_scan_gen_pkg.sv
// vga_scan_gen shared definitions.
// Default 640x480@60 timing and display-stage bundle.
package vga_scan_gen_pkg;

  localparam int H_DISP_LEN = 10;
  localparam int V_DISP_LEN = 10;

  localparam int COLOR_R_DEPTH = 4;
  localparam int COLOR_G_DEPTH = 4;
  localparam int COLOR_B_DEPTH = 4;

  localparam int DEF_H_DISP = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_DISP = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
  } disp_t;

endpackage

// File: rtl/vga_scan_gen_if.sv
// Request/display bundle between scan generator
// and the pixel responder.
interface vga_scan_gen_if;
  import vga_scan_gen_pkg::*;

  logic                  en_i;
  logic                  req_en_o;
  logic [H_DISP_LEN-1:0] req_h_addr_o;
  logic [V_DISP_LEN-1:0] req_v_addr_o;
  logic                  frame_start_o;
  logic                  line_start_o;
  logic                  h_sync_o;
  logic                  v_sync_o;
  logic                  disp_o;

  modport master (
    input  en_i,
    output req_en_o,
    output req_h_addr_o,
    output req_v_addr_o,
    output frame_start_o,
    output line_start_o,
    output h_sync_o,
    output v_sync_o,
    output disp_o
  );

  modport slave (
    output en_i,
    input  req_en_o,
    input  req_h_addr_o,
    input  req_v_addr_o,
    input  frame_start_o,
    input  line_start_o,
    input  h_sync_o,
    input  v_sync_o,
    input  disp_o
  );

endinterface

// File: rtl/vga_delay_line.sv
// Width/depth shift register with synchronous flush.
// Depth 0 passes the input straight through.
module vga_delay_line #(
  parameter int             W     = 1,
  parameter int             DEPTH = 1,
  parameter logic [W-1:0]   IDLE  = '0
) (
  input  logic         clk,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_pass;
    assign unused_pass = ^{clk, flush};
    assign q = d;
  end else begin : g_pipe
    logic [W-1:0] pipe [DEPTH];

    always_ff @(posedge clk) begin
      if (flush) begin
        for (int i = 0; i < DEPTH; i++)
          pipe[i] <= IDLE;
      end else begin
        pipe[0] <= d;
        for (int i = 1; i < DEPTH; i++)
          pipe[i] <= pipe[i-1];
      end
    end

    assign q = pipe[DEPTH-1];
  end

endmodule

// File: rtl/vga_scan_gen.sv
// VGA scan-timing initiator: counters, pixel requests
// and LEAD-delayed sync/visible outputs.
module vga_scan_gen
  import vga_scan_gen_pkg::*;
#(
  parameter int   H_DISP   = DEF_H_DISP,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_DISP   = DEF_V_DISP,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0,
  parameter int   LEAD     = 1
) (
  input  logic           clk,
  input  logic           rst,
  vga_scan_gen_if.master bus
);

  localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  localparam logic [HW-1:0] H_VIS  = HW'(H_DISP);
  localparam logic [HW-1:0] HS_LO  = HW'(H_DISP + H_FP);
  localparam logic [HW-1:0] HS_HI  = HW'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_DISP);
  localparam logic [VW-1:0] VS_LO  = VW'(V_DISP + V_FP);
  localparam logic [VW-1:0] VS_HI  = VW'(V_DISP + V_FP + V_SYNC - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);

  localparam disp_t IDLE = '{vis: 1'b0, hs: ~SYNC_POL, vs: ~SYNC_POL};

  logic                  halt;
  logic                  run;
  logic [HW-1:0]         hc;
  logic [VW-1:0]         vc;
  logic                  vis;
  logic                  hs_on;
  logic                  vs_on;
  logic                  req_en;
  logic [H_DISP_LEN-1:0] req_h;
  logic [V_DISP_LEN-1:0] req_v;
  logic                  fs;
  logic                  ls;
  logic                  hs_r;
  logic                  vs_r;
  disp_t                 raw;
  disp_t                 lead_q;

  assign halt  = rst | ~bus.en_i;
  assign vis   = (hc < H_VIS) && (vc < V_VIS);
  assign hs_on = (hc >= HS_LO) && (hc <= HS_HI);
  assign vs_on = (vc >= VS_LO) && (vc <= VS_HI);

  // run holds the counters at (0,0) for one edge after
  // start, so (0,0) is requested on the second edge.
  always_ff @(posedge clk) begin
    if (halt) begin
      run    <= 1'b0;
      hc     <= '0;
      vc     <= '0;
      req_en <= 1'b0;
      req_h  <= '0;
      req_v  <= '0;
      fs     <= 1'b0;
      ls     <= 1'b0;
      hs_r   <= ~SYNC_POL;
      vs_r   <= ~SYNC_POL;
    end else begin
      run <= 1'b1;
      if (run) begin
        if (hc == H_LAST) begin
          hc <= '0;
          vc <= (vc == V_LAST) ? '0 : vc + VW'(1);
        end else begin
          hc <= hc + HW'(1);
        end
      end
      req_en <= run && vis;
      req_h  <= (run && vis) ? H_DISP_LEN'(hc) : '0;
      req_v  <= (run && vis) ? V_DISP_LEN'(vc) : '0;
      fs     <= run && (hc == '0) && (vc == '0);
      ls     <= run && (hc == '0) && (vc < V_VIS);
      hs_r   <= (run && hs_on) ? SYNC_POL : ~SYNC_POL;
      vs_r   <= (run && vs_on) ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign raw = '{vis: req_en, hs: hs_r, vs: vs_r};

  vga_delay_line #(
    .W     ($bits(disp_t)),
    .DEPTH (LEAD),
    .IDLE  (IDLE)
  ) u_lead (
    .clk   (clk),
    .flush (halt),
    .d     (raw),
    .q     (lead_q)
  );

  assign bus.req_en_o      = req_en;
  assign bus.req_h_addr_o  = req_h;
  assign bus.req_v_addr_o  = req_v;
  assign bus.frame_start_o = fs;
  assign bus.line_start_o  = ls;
  assign bus.disp_o        = lead_q.vis;
  assign bus.h_sync_o      = lead_q.hs;
  assign bus.v_sync_o      = lead_q.vs;

endmodule
